// File: rtl/bubble_sort_pkg.sv
// bubble_sort_pkg
//   Shared definitions for the bubble-sort control block:
//   - one-hot state encoding (bit index constants plus the enum built on them)
//   - default counter width
//   - saturating increment helper used by sat_counter
// Optional feature macro used by the top: BUBBLE_SWAP_COUNT_EN.
package bubble_sort_pkg;

  localparam int CNT_W_DEFAULT = 8;

  // Bit positions of the one-hot state vector; outputs decode single bits.
  localparam int ST_IDLE     = 0;
  localparam int ST_START    = 1;
  localparam int ST_COMPARE  = 2;
  localparam int ST_WR_LO    = 3;
  localparam int ST_WR_HI    = 4;
  localparam int ST_PASS_END = 5;
  localparam int ST_DONE     = 6;
  localparam int NUM_STATES  = 7;

  typedef enum logic [NUM_STATES-1:0] {
    S_IDLE     = 7'b000_0001,
    S_START    = 7'b000_0010,
    S_COMPARE  = 7'b000_0100,
    S_WR_LO    = 7'b000_1000,
    S_WR_HI    = 7'b001_0000,
    S_PASS_END = 7'b010_0000,
    S_DONE     = 7'b100_0000
  } state_t;

  // Increment that sticks at the all-ones value of a 'width'-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (value == max_val) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/array_bubble_sort_control_sat_counter.sv
// sat_counter
//   Clearable, saturating up-counter.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-high reset, count -> 0
//   clear  - synchronous clear (wins over enable)
//   enable - count up by one, holding at all-ones
//   count  - current value [W]
module sat_counter
  import bubble_sort_pkg::*;
#(
  parameter int W = CNT_W_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  output logic [W-1:0] count
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= W'(sat_inc(32'(count), W));
    end
  end

endmodule

// File: rtl/array_bubble_sort_control.sv
// array_bubble_sort_control
//   Control FSM for an in-place ascending bubble sort. Repeats full passes over
//   the array until one pass makes no swap, then raises done.
// Ports:
//   clock, reset          - rising-edge clock, asynchronous active-high reset
//   go                    - level start request
//   inversion_found       - A[i] > A[i+1]
//   end_of_array          - i+1 == length
//   zero_length_array     - length == 0
//   load_input            - capture array base/length
//   load_index            - write index register
//   select_index          - index mux: 0 -> load 0, 1 -> load i+1
//   latch_pair            - capture A[i], A[i+1] into temps
//   write_lo / write_hi   - A[i] <- temp hi / A[i+1] <- temp lo
//   done                  - sort complete
//   pass_count [CNT_W]    - passes completed this run
//   swap_count [CNT_W]    - swaps this run (only with BUBBLE_SWAP_COUNT_EN)
//   state                 - one-hot FSM state, for observation
// Handshake: go is a level; a run starts when go is seen in IDLE or DONE, and
// the FSM waits in START until go drops. done stays high until the next go.
// Optional feature macro: BUBBLE_SWAP_COUNT_EN adds swap_count.
module array_bubble_sort_control
  import bubble_sort_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic             inversion_found,
  input  logic             end_of_array,
  input  logic             zero_length_array,
  output logic             load_input,
  output logic             load_index,
  output logic             select_index,
  output logic             latch_pair,
  output logic             write_lo,
  output logic             write_hi,
  output logic             done,
  output logic [CNT_W-1:0] pass_count,
`ifdef BUBBLE_SWAP_COUNT_EN
  output logic [CNT_W-1:0] swap_count,
`endif
  output state_t           state
);

  logic swapped;
  logic cmp_advance;  // COMPARE with an in-order pair: step to i+1
  logic cmp_swap;     // COMPARE with an inversion: latch the pair

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      swapped <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (go) state <= S_START;
        end
        S_START: begin
          swapped <= 1'b0;
          if (!go) state <= S_COMPARE;
        end
        S_COMPARE: begin
          if (zero_length_array)    state <= S_DONE;
          else if (end_of_array)    state <= S_PASS_END;
          else if (inversion_found) state <= S_WR_LO;
        end
        S_WR_LO: begin
          state <= S_WR_HI;
        end
        S_WR_HI: begin
          swapped <= 1'b1;
          state   <= S_COMPARE;
        end
        S_PASS_END: begin
          // Another pass only if this one moved something.
          swapped <= 1'b0;
          state   <= swapped ? S_COMPARE : S_DONE;
        end
        S_DONE: begin
          if (go) state <= S_START;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // COMPARE outputs follow the status inputs in the same cycle (priority
  // zero-length > end-of-array > inversion); all others decode one state bit.
  assign cmp_advance  = state[ST_COMPARE] & ~zero_length_array & ~end_of_array
                        & ~inversion_found;
  assign cmp_swap     = state[ST_COMPARE] & ~zero_length_array & ~end_of_array
                        & inversion_found;

  assign load_input   = state[ST_START];
  assign load_index   = state[ST_START] | cmp_advance | state[ST_WR_HI]
                        | (state[ST_PASS_END] & swapped);
  assign select_index = cmp_advance | state[ST_WR_HI];
  assign latch_pair   = cmp_swap;
  assign write_lo     = state[ST_WR_LO];
  assign write_hi     = state[ST_WR_HI];
  assign done         = state[ST_DONE];

  sat_counter #(.W(CNT_W)) u_pass_count (
    .clock  (clock),
    .reset  (reset),
    .clear  (state[ST_START]),
    .enable (state[ST_PASS_END]),
    .count  (pass_count)
  );

`ifdef BUBBLE_SWAP_COUNT_EN
  sat_counter #(.W(CNT_W)) u_swap_count (
    .clock  (clock),
    .reset  (reset),
    .clear  (state[ST_START]),
    .enable (state[ST_WR_HI]),
    .count  (swap_count)
  );
`endif

endmodule

// File: tb/tb_array_bubble_sort_control.sv
// tb_array_bubble_sort_control
//   Bench for array_bubble_sort_control with a behavioural array/index
//   datapath that reacts to the control outputs and feeds back the status
//   inputs. Elements are 4-bit, up to 8 per array, packed into 32-bit words
//   (element k at bits [4k+3:4k]).
module tb_array_bubble_sort_control;
  import bubble_sort_pkg::*;

  localparam int CNT_W   = 8;
  localparam int MAX_LEN = 8;
  localparam int NVEC    = 9;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset, go;
  logic inversion_found, end_of_array, zero_length_array;
  logic load_input, load_index, select_index, latch_pair;
  logic write_lo, write_hi, done;
  logic [CNT_W-1:0] pass_count;
`ifdef BUBBLE_SWAP_COUNT_EN
  logic [CNT_W-1:0] swap_count;
`endif
  state_t state;

  always #5 clock = ~clock;

  array_bubble_sort_control #(.CNT_W(CNT_W)) dut (
    .clock             (clock),
    .reset             (reset),
    .go                (go),
    .inversion_found   (inversion_found),
    .end_of_array      (end_of_array),
    .zero_length_array (zero_length_array),
    .load_input        (load_input),
    .load_index        (load_index),
    .select_index      (select_index),
    .latch_pair        (latch_pair),
    .write_lo          (write_lo),
    .write_hi          (write_hi),
    .done              (done),
    .pass_count        (pass_count),
`ifdef BUBBLE_SWAP_COUNT_EN
    .swap_count        (swap_count),
`endif
    .state             (state)
  );

  // ---------------- datapath model ----------------
  logic [3:0] init_mem [0:MAX_LEN];
  logic [3:0] mem      [0:MAX_LEN];  // spare slot keeps A[i+1] in range
  int         len_in;
  int         len_q = 0;
  int         idx = 0;
  logic [3:0] tmp_lo, tmp_hi;

  always @(posedge clock) begin
    if (load_input) begin
      mem   <= init_mem;
      len_q <= len_in;
    end
    if (load_index) idx <= select_index ? idx + 1 : 0;
    if (latch_pair) begin
      tmp_lo <= mem[idx];
      tmp_hi <= mem[idx + 1];
    end
    if (write_lo) mem[idx]     <= tmp_hi;
    if (write_hi) mem[idx + 1] <= tmp_lo;
  end

  always_comb begin
    zero_length_array = (len_q == 0);
    end_of_array      = (idx + 1 == len_q);
    inversion_found   = 1'b0;
    if ((idx + 1 < len_q) && (idx < MAX_LEN))
      inversion_found = (mem[idx] > mem[idx + 1]);
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] data;
    int          len;
    logic [31:0] exp_sorted;
    int          exp_passes;
    int          exp_swaps;
    int          exp_cycles;  // cycle of first done, go driven in cycle 0
  } vec_t;

  vec_t        vecs [NVEC];
  logic [31:0] exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference bubble sort with cycle cost: 2 cycles to first COMPARE, then
  // 1 per in-order pair, 3 per swapped pair, 2 per end of pass; an empty
  // array finishes one cycle after its COMPARE.
  function automatic vec_t ref_sort(input logic [31:0] d, input int n);
    vec_t       v;
    logic [3:0] a [MAX_LEN];
    logic [3:0] t;
    bit         sw;
    for (int k = 0; k < MAX_LEN; k++) a[k] = d[4*k +: 4];
    v.data = d; v.len = n; v.exp_passes = 0; v.exp_swaps = 0;
    v.exp_cycles = 2; v.exp_sorted = '0;
    if (n == 0) begin
      v.exp_cycles = 3;
    end else begin
      do begin
        sw = 1'b0;
        for (int i = 0; i < n - 1; i++) begin
          if (a[i] > a[i+1]) begin
            t = a[i]; a[i] = a[i+1]; a[i+1] = t;
            sw = 1'b1; v.exp_swaps++; v.exp_cycles += 3;
          end else begin
            v.exp_cycles += 1;
          end
        end
        v.exp_cycles += 2;
        v.exp_passes++;
      end while (sw);
    end
    for (int k = 0; k < n; k++) v.exp_sorted[4*k +: 4] = a[k];
    return v;
  endfunction

  task automatic load_array(input logic [31:0] d, input int n);
    for (int k = 0; k < MAX_LEN; k++) init_mem[k] = d[4*k +: 4];
    init_mem[MAX_LEN] = '0;
    len_in = n;
  endtask

  // ---------------- driver: one full run with a 1-cycle go pulse ----------------
  task automatic run_vec(input vec_t v, input string tag);
    int          cyc;
    int          n_lo, n_hi, n_inc;
    logic [31:0] act, exp;
    load_array(v.data, v.len);
    exp_q.push_back(v.exp_sorted);
    n_lo = 0; n_hi = 0; n_inc = 0;
    @(negedge clock); go = 1'b1;          // cycle 0
    @(negedge clock); go = 1'b0; cyc = 1; // cycle 1: START
    while (!done && cyc < 400) begin
      if (write_lo) n_lo++;
      if (write_hi) n_hi++;
      if (load_index && select_index) n_inc++;
      if (cyc == 2) check({tag, " pass_count_cleared"}, 32'(pass_count), 0);
      @(negedge clock); cyc++;
    end
    check({tag, " done_seen"}, 32'(done), 1);
    check({tag, " done_cycle"}, cyc, v.exp_cycles);
    act = '0;
    for (int k = 0; k < v.len; k++) act[4*k +: 4] = mem[k];
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    else exp = '1;
    check({tag, " sorted_array"}, act, exp);
    check({tag, " pass_count"}, 32'(pass_count), v.exp_passes);
    check({tag, " write_lo_count"}, n_lo, v.exp_swaps);
    check({tag, " write_hi_count"}, n_hi, v.exp_swaps);
`ifdef BUBBLE_SWAP_COUNT_EN
    check({tag, " swap_count"}, 32'(swap_count), v.exp_swaps);
`endif
    if (v.len == 0) check({tag, " no_index_step"}, n_inc, 0);
    // pass_count and done hold while go stays low
    @(negedge clock);
    check({tag, " done_hold"}, 32'(done), 1);
    check({tag, " pass_count_hold"}, 32'(pass_count), v.exp_passes);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int          wait_cyc;
    logic [31:0] d;
    int          n;

    // Hand-derived expectations for the documented cases.
    vecs[0] = '{data:32'h0000_0213, len:3, exp_sorted:32'h0000_0321,
                exp_passes:2, exp_swaps:2, exp_cycles:14};
    vecs[1] = '{data:32'h0000_4321, len:4, exp_sorted:32'h0000_4321,
                exp_passes:1, exp_swaps:0, exp_cycles:7};
    vecs[2] = '{data:32'h0000_0000, len:0, exp_sorted:32'h0000_0000,
                exp_passes:0, exp_swaps:0, exp_cycles:3};
    vecs[3] = '{data:32'h0000_1234, len:4, exp_sorted:32'h0000_4321,
                exp_passes:4, exp_swaps:6, exp_cycles:34};
    vecs[4] = '{data:32'h0000_0005, len:1, exp_sorted:32'h0000_0005,
                exp_passes:1, exp_swaps:0, exp_cycles:4};
    for (int k = 5; k < NVEC; k++) begin
      n = $urandom_range(MAX_LEN, 2);
      d = '0;
      for (int j = 0; j < n; j++) d[4*j +: 4] = 4'($urandom_range(15, 0));
      vecs[k] = ref_sort(d, n);
    end

    reset = 1'b1; go = 1'b0; len_in = 0;
    for (int k = 0; k <= MAX_LEN; k++) init_mem[k] = '0;
    repeat (3) @(negedge clock);
    check("reset_state", 32'(state), 32'(S_IDLE));
    check("reset_outputs", {load_input, load_index, select_index, latch_pair,
                            write_lo, write_hi, done}, 0);
    check("reset_pass_count", 32'(pass_count), 0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_without_go", 32'(state), 32'(S_IDLE));

    // Table: first run starts from IDLE, the rest restart from DONE.
    for (int k = 0; k < NVEC; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

    // go held for 5 cycles: START every cycle, COMPARE once go drops.
    load_array(32'h0000_4321, 4);
    @(negedge clock); go = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      check($sformatf("hold_start_%0d", k), 32'(state), 32'(S_START));
      check($sformatf("hold_load_input_%0d", k), 32'(load_input), 1);
    end
    go = 1'b0;
    @(negedge clock);
    check("hold_then_compare", 32'(state), 32'(S_COMPARE));
    wait_cyc = 0;
    while (!done && wait_cyc < 100) begin @(negedge clock); wait_cyc++; end
    check("hold_run_done", 32'(done), 1);
    check("hold_run_passes", 32'(pass_count), 1);

    // Reset in WR_LO during the second pass of [4,3,2,1].
    load_array(32'h0000_1234, 4);
    @(negedge clock); go = 1'b1;
    @(negedge clock); go = 1'b0;
    wait_cyc = 0;
    while (!(write_lo && pass_count == 1) && wait_cyc < 200) begin
      @(negedge clock); wait_cyc++;
    end
    check("abort_reached_wr_lo", 32'(write_lo), 1);
    reset = 1'b1;
    #1;
    check("abort_state", 32'(state), 32'(S_IDLE));
    check("abort_outputs", {load_input, load_index, select_index, latch_pair,
                            write_lo, write_hi, done}, 0);
    check("abort_pass_count", 32'(pass_count), 0);
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
    check("abort_stays_idle", 32'(state), 32'(S_IDLE));

    // A fresh run after the abort must behave normally.
    run_vec(vecs[0], "after_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
